rf_writeback_queue: RTL and testbench
=====================================

Name: rf_writeback_queue

Overview:
- Write-side companion to the 32x32 register file.
- Buffers completed results (rd, data) from the execute/memory stages and drains them, one per cycle, into the register file write port (WE3/A3/WD3).
- Decode-stage read addresses can look up pending entries through forwarding ports, so reads never return stale data while writes are queued.
- Sits between the MEM/WB pipeline register and the register file.

Parameters:
- DEPTH, 4, number of queue entries; power of two, at least 2.
- XLEN, 32, data width.
- AW, 5, register address width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  result available from the producer.
- in_ready  output  1  queue can accept a result this cycle.
- in_rd  input  AW  destination register.
- in_data  input  XLEN  result value.
- rf_hold  input  1  write port unavailable this cycle; no drain.
- rf_we  output  1  register file write enable (to WE3).
- rf_addr  output  AW  register file write address (to A3).
- rf_wdata  output  XLEN  register file write data (to WD3).
- q_a1  input  AW  lookup address 1 (mirrors A1).
- q_a2  input  AW  lookup address 2 (mirrors A2).
- fwd1_hit  output  1  a pending write exists for q_a1.
- fwd1_data  output  XLEN  youngest pending value for q_a1.
- fwd2_hit  output  1  a pending write exists for q_a2.
- fwd2_data  output  XLEN  youngest pending value for q_a2.
- count  output  clog2(DEPTH+1)  number of occupied entries.

Behaviour:
- Storage: circular buffer with head/tail pointers (log2 DEPTH bits, natural wrap) and a count register (0..DEPTH).
- Reset (rst=1 at a clock edge): head, tail and count go to 0.
  - Entry payloads are not reset.
  - As a result: count=0, in_ready=1, rf_we=0, fwd1_hit=0, fwd2_hit=0.
  - Reset mid-operation discards all pending entries. Nothing is written after reset.
- in_ready = (count != DEPTH). It depends only on registered state, with no combinational path from rf_hold.
- Push on an edge where in_valid && in_ready:
  - in_rd != 0: store {in_rd, in_data} at tail; tail advances.
  - in_rd == 0: the handshake completes but nothing is stored, and count is unchanged (x0 writes are discarded).
- Drain (combinational outputs):
  - rf_we = (count != 0) && !rf_hold.
  - rf_addr and rf_wdata are the head entry.
  - rf_addr and rf_wdata are 0 when count == 0.
- Pop: on an edge where rf_we=1, head advances.
- Latency: a result accepted at edge N can be written to the register file at edge N+1 at the earliest.
- Simultaneous push (rd != 0) and pop: count unchanged, both pointers advance.
- Full: no push is possible; a pop in that cycle frees a slot visible the next cycle.
- Empty: no pop; a push makes the entry drainable from the next cycle.
- rf_hold held high: the queue stops draining and fills until in_ready=0. Contents and order are preserved.
- Forwarding (combinational):
  - For each lookup, fwdN_hit = 1 when q_aN != 0 and some occupied entry has rd == q_aN.
  - fwdN_data is the data of the youngest such entry (closest to tail).
  - No hit gives fwdN_data = 0.
  - The entry being popped this cycle still counts as pending, because the register file write lands at the same edge.
- Ordering: strict FIFO. Multiple pending writes to the same rd are written oldest first, so the register file ends with the youngest value.

Optional Feature:
- Macro: RF_WBQ_BYPASS_IN_EN.
- Defined: the incoming result is included in forwarding as the youngest candidate when in_valid && in_ready && in_rd != 0 && in_rd == q_aN. It overrides matching queued entries the same cycle.
- Undefined: forwarding covers only occupied entries. An incoming result is visible one cycle after acceptance.
- Queue/drain behaviour is identical in both builds.

Test Plan:
- Reset, then push rd=5, data=0x11 with rf_hold=0:
  - The next cycle has rf_we=1, rf_addr=5, rf_wdata=0x11.
  - The edge after that gives count=0 and rf_we=0.
- Push rd=0, data=0xFFFF:
  - in_ready=1 and the handshake completes.
  - count stays 0, rf_we is never asserted, fwd hits stay 0.
- Hold rf_hold=1 and push rd=1..4 (data 0xA1..0xA4):
  - count=4, in_ready=0, and a fifth push is refused.
  - Release rf_hold: writes occur to 1, 2, 3, 4 in order on consecutive cycles.
- With rf_hold=1, push rd=7 data=0x10, then rd=7 data=0x20; set q_a1=7, q_a2=0:
  - fwd1_hit=1 with fwd1_data=0x20.
  - fwd2_hit=0.
  - After draining, the final write to 7 is 0x20.
- With count=1 (rd=3), push rd=9 on the same cycle rd=3 drains:
  - count stays 1, next rf_addr=9.
  - Full-queue wrap: run 10 push/pop pairs and check data order is preserved.
- Fill 3 entries, assert rst for one cycle:
  - count=0, rf_we=0, no further writes.
- With the macro defined, push rd=12 data=0x55 with q_a1=12 into an empty queue:
  - fwd1_hit=1 and fwd1_data=0x55 in the same cycle.
- With the macro undefined: fwd1_hit=0 that cycle and 1 the next.

Source files
------------

// File: rtl/rf_writeback_queue.sv
// rf_writeback_queue
//
// Buffers completed results (rd, data) between the MEM/WB pipeline register
// and the register file, and drains them into the register file write port
// (WE3/A3/WD3) at most one per cycle, oldest first. Pending entries can be
// looked up by the decode-stage read addresses, so a read never returns a
// value that is still waiting in the queue.
//
// Optional feature (macro RF_WBQ_BYPASS_IN_EN):
//   defined   - a result being accepted this cycle also takes part in the
//               forwarding lookup, as the youngest candidate.
//   undefined - only occupied entries are forwarded; an incoming result
//               becomes visible the cycle after it is accepted.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     producer handshake; in_rd/in_data carry the result
//   rf_hold               write port busy this cycle, do not drain
//   rf_we/rf_addr/rf_wdata register file write port (head entry)
//   q_a1/q_a2             lookup addresses (mirror A1/A2)
//   fwdN_hit/fwdN_data    youngest pending value for q_aN
//   count                 number of occupied entries

module rf_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int AW    = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [AW-1:0]              in_rd,
    input  logic [XLEN-1:0]            in_data,
    input  logic                       rf_hold,
    output logic                       rf_we,
    output logic [AW-1:0]              rf_addr,
    output logic [XLEN-1:0]            rf_wdata,
    input  logic [AW-1:0]              q_a1,
    input  logic [AW-1:0]              q_a2,
    output logic                       fwd1_hit,
    output logic [XLEN-1:0]            fwd1_data,
    output logic                       fwd2_hit,
    output logic [XLEN-1:0]            fwd2_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW-1:0]   rd_q   [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;

    logic push_en;
    logic pop_en;

    assign in_ready = (count_q != CW'(DEPTH));
    assign rf_we    = (count_q != '0) && !rf_hold;
    assign rf_addr  = (count_q != '0) ? rd_q[head_q]   : '0;
    assign rf_wdata = (count_q != '0) ? data_q[head_q] : '0;
    assign count    = count_q;

    // x0 results complete the handshake but are never stored
    assign push_en = in_valid && in_ready && (in_rd != '0);
    assign pop_en  = rf_we;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop_en) begin
            head_d = head_q + PW'(1);
        end
        if (push_en) begin
            tail_d = tail_q + PW'(1);
        end
        if (push_en && !pop_en) begin
            count_d = count_q + CW'(1);
        end else if (!push_en && pop_en) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payloads are deliberately not reset; count gates every use of them.
    always_ff @(posedge clk) begin
        if (push_en) begin
            rd_q[tail_q]   <= in_rd;
            data_q[tail_q] <= in_data;
        end
    end

    // Walk from oldest to youngest so the last match wins. The head entry is
    // included even while it is being popped: its register file write only
    // lands at the coming edge.
    function automatic logic [XLEN:0] lookup(input logic [AW-1:0] addr);
        logic            hit;
        logic [XLEN-1:0] dat;
        logic [PW-1:0]   idx;
        hit = 1'b0;
        dat = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if ((CW'(k) < count_q) && (addr != '0) && (rd_q[idx] == addr)) begin
                hit = 1'b1;
                dat = data_q[idx];
            end
        end
        return {hit, dat};
    endfunction

    always_comb begin
        {fwd1_hit, fwd1_data} = lookup(q_a1);
        {fwd2_hit, fwd2_data} = lookup(q_a2);
`ifdef RF_WBQ_BYPASS_IN_EN
        if (push_en && (in_rd == q_a1)) begin
            fwd1_hit  = 1'b1;
            fwd1_data = in_data;
        end
        if (push_en && (in_rd == q_a2)) begin
            fwd2_hit  = 1'b1;
            fwd2_data = in_data;
        end
`else
`endif
    end

endmodule

// File: tb/tb_rf_writeback_queue.sv
module tb_rf_writeback_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [31:0] in_data;
    logic        rf_hold;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wdata;
    logic [4:0]  q_a1;
    logic [4:0]  q_a2;
    logic        fwd1_hit;
    logic [31:0] fwd1_data;
    logic        fwd2_hit;
    logic [31:0] fwd2_data;
    logic [2:0]  count;

    rf_writeback_queue #(.DEPTH(4), .XLEN(32), .AW(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rd     (in_rd),
        .in_data   (in_data),
        .rf_hold   (rf_hold),
        .rf_we     (rf_we),
        .rf_addr   (rf_addr),
        .rf_wdata  (rf_wdata),
        .q_a1      (q_a1),
        .q_a2      (q_a2),
        .fwd1_hit  (fwd1_hit),
        .fwd1_data (fwd1_data),
        .fwd2_hit  (fwd2_hit),
        .fwd2_data (fwd2_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every register file write must match the oldest
    // expected write.
    always @(negedge clk) begin
        if (rst === 1'b0 && rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got rd=%0d data=0x%0h expected no write at %0t",
                         rf_addr, rf_wdata, $time);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", {27'd0, rf_addr}, {27'd0, e.rd});
                chk("wr_data", rf_wdata, e.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one push for one cycle; acc is the hand-computed in_ready.
    task automatic push(input logic [4:0] rd, input logic [31:0] d, input logic acc);
        in_valid = 1'b1;
        in_rd    = rd;
        in_data  = d;
        @(negedge clk);
        chk("in_ready", {31'd0, in_ready}, {31'd0, acc});
        if (acc && rd != 5'd0) begin
            exp_q.push_back('{rd, d});
        end
        step();
        in_valid = 1'b0;
        in_rd    = '0;
        in_data  = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_data = '0;
        rf_hold = 1'b0; q_a1 = 5'd5; q_a2 = 5'd3;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
        chk("rst_rf_addr", {27'd0, rf_addr}, 32'd0);
        chk("rst_fwd1_hit", {31'd0, fwd1_hit}, 32'd0);
        chk("rst_fwd2_hit", {31'd0, fwd2_hit}, 32'd0);
        step();

        // single push, drained the next cycle
        push(5'd5, 32'h11, 1'b1);
        @(negedge clk);
        chk("t1_rf_we", {31'd0, rf_we}, 32'd1);
        chk("t1_rf_addr", {27'd0, rf_addr}, 32'd5);
        chk("t1_rf_wdata", rf_wdata, 32'h11);
        chk("t1_count", {29'd0, count}, 32'd1);
        chk("t1_fwd1", {fwd1_hit, fwd1_data[30:0]}, {1'b1, 31'h11});
        step();
        @(negedge clk);
        chk("t1_count_after", {29'd0, count}, 32'd0);
        chk("t1_rf_we_after", {31'd0, rf_we}, 32'd0);

        // x0 result is discarded
        q_a1 = 5'd0; q_a2 = 5'd0;
        push(5'd0, 32'hFFFF, 1'b1);
        @(negedge clk);
        chk("x0_count", {29'd0, count}, 32'd0);
        chk("x0_rf_we", {31'd0, rf_we}, 32'd0);
        chk("x0_fwd1_hit", {31'd0, fwd1_hit}, 32'd0);
        chk("x0_fwd2_hit", {31'd0, fwd2_hit}, 32'd0);
        step();

        // fill under hold, refuse a fifth push, then drain in order
        rf_hold = 1'b1;
        for (int i = 1; i <= 4; i++) push(5'(i), 32'hA0 + 32'(i), 1'b1);
        @(negedge clk);
        chk("full_count", {29'd0, count}, 32'd4);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        chk("full_rf_we", {31'd0, rf_we}, 32'd0);
        step();
        push(5'd5, 32'hA5, 1'b0);
        q_a1 = 5'd3; q_a2 = 5'd4;
        @(negedge clk);
        chk("full_count_refused", {29'd0, count}, 32'd4);
        chk("full_fwd1", {fwd1_hit, fwd1_data[30:0]}, {1'b1, 31'hA3});
        chk("full_fwd2", {fwd2_hit, fwd2_data[30:0]}, {1'b1, 31'hA4});
        step();
        rf_hold = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("drain_order", {27'd0, rf_addr}, 32'(i));
            step();
        end
        @(negedge clk);
        chk("drain_count", {29'd0, count}, 32'd0);
        step();

        // youngest pending value wins
        rf_hold = 1'b1;
        push(5'd7, 32'h10, 1'b1);
        push(5'd7, 32'h20, 1'b1);
        q_a1 = 5'd7; q_a2 = 5'd0;
        @(negedge clk);
        chk("dup_fwd1_hit", {31'd0, fwd1_hit}, 32'd1);
        chk("dup_fwd1_data", fwd1_data, 32'h20);
        chk("dup_fwd2_hit", {31'd0, fwd2_hit}, 32'd0);
        chk("dup_fwd2_data", fwd2_data, 32'd0);
        step();
        rf_hold = 1'b0;
        repeat (2) step();
        @(negedge clk);
        chk("dup_count", {29'd0, count}, 32'd0);
        step();

        // simultaneous push and pop at count 1
        q_a1 = 5'd0;
        push(5'd3, 32'h33, 1'b1);
        push(5'd9, 32'h99, 1'b1);
        @(negedge clk);
        chk("pp_count", {29'd0, count}, 32'd1);
        chk("pp_rf_addr", {27'd0, rf_addr}, 32'd9);
        chk("pp_rf_wdata", rf_wdata, 32'h99);
        step();

        // pointer wrap: 10 push/pop pairs around a standing occupancy of 3
        rf_hold = 1'b1;
        for (int i = 0; i < 3; i++) push(5'(20 + i), 32'hC00 + 32'(i), 1'b1);
        rf_hold = 1'b0;
        for (int i = 0; i < 10; i++) push(5'(10 + i), 32'h100 + 32'(i), 1'b1);
        @(negedge clk);
        chk("wrap_count", {29'd0, count}, 32'd3);
        step();
        repeat (2) step();
        @(negedge clk);
        chk("wrap_count_end", {29'd0, count}, 32'd0);
        step();

        // reset mid-operation discards pending entries
        rf_hold = 1'b1;
        for (int i = 1; i <= 3; i++) push(5'(i), 32'hB0 + 32'(i), 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        rf_hold = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("mrst_count", {29'd0, count}, 32'd0);
        chk("mrst_rf_we", {31'd0, rf_we}, 32'd0);
        chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        repeat (4) step();
        @(negedge clk);
        chk("mrst_count_later", {29'd0, count}, 32'd0);
        step();

        // incoming result visibility in the forwarding path
        q_a1 = 5'd12;
        in_valid = 1'b1; in_rd = 5'd12; in_data = 32'h55;
        @(negedge clk);
`ifdef RF_WBQ_BYPASS_IN_EN
        chk("byp_fwd1_hit", {31'd0, fwd1_hit}, 32'd1);
        chk("byp_fwd1_data", fwd1_data, 32'h55);
`else
        chk("byp_fwd1_hit", {31'd0, fwd1_hit}, 32'd0);
        chk("byp_fwd1_data", fwd1_data, 32'd0);
`endif
        exp_q.push_back('{5'd12, 32'h55});
        step();
        in_valid = 1'b0; in_rd = '0; in_data = '0;
        @(negedge clk);
        chk("byp_next_hit", {31'd0, fwd1_hit}, 32'd1);
        chk("byp_next_data", fwd1_data, 32'h55);
        step();
        @(negedge clk);
        chk("byp_end_count", {29'd0, count}, 32'd0);
        chk("byp_end_hit", {31'd0, fwd1_hit}, 32'd0);

        repeat (2) step();
        chk("pending_writes_left", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
